// File: rtl/synchronizer_pkg.sv
// Purpose: shared edge-select encodings for the single-bit ack synchronizer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package synchronizer_pkg;

   // Which edge of the synchronized level produces a pulse.
   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_BOTH = 2;

endpackage : synchronizer_pkg

// File: rtl/synchronizer_sync_chain.sv
// Purpose: N-flop resampling chain bringing an asynchronous level into clk_i.
// Latency: a level stable across a sampling edge reaches q_o after SYNC_STAGES edges.
// Backpressure: none; free-running, every edge shifts the chain.
//
// Ports:
//   clk_i  - destination-domain clock, rising edge
//   rst_ni - synchronous active-low reset, clears every stage
//   d_i    - asynchronous input level
//   q_o    - synchronized level (last stage)
module synchronizer_sync_chain #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   // Stage 0 is the only flop that may go metastable; the chain must stay
   // physically adjacent so each stage gets a full period to resolve.
   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule : synchronizer_sync_chain

// File: rtl/synchronizer.sv
// Purpose: synchronize an async ack level and turn the selected edge into a 1-cycle pulse.
// Latency: ack_double_FF follows ack after SYNC_STAGES edges; pulse in the same cycle it changes.
// Backpressure: none; sub-period ack pulses may be dropped, nothing is stretched.
//
// Ports:
//   clk           - destination-domain clock, rising edge
//   rst           - synchronous active-low reset
//   ack           - asynchronous acknowledge level from the foreign domain
//   ack_double_FF - synchronized ack level
//   ack_lvl_pulse - one-cycle pulse on the edge chosen by EDGE_MODE
module synchronizer
   import synchronizer_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_MODE   = EDGE_RISE
) (
   input  logic clk,
   input  logic rst,
   input  logic ack,
   output logic ack_double_FF,
   output logic ack_lvl_pulse
);

   // Elaboration-time legality checks.
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("synchronizer: SYNC_STAGES must be 2..4");
   end
   if (EDGE_MODE > EDGE_BOTH) begin : g_bad_mode
      $error("synchronizer: EDGE_MODE must be 0, 1 or 2");
   end

   logic sync_lvl;
   logic ack_q;
   logic ack_d;
   logic pulse_d;

   synchronizer_sync_chain #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_chain (
      .clk_i (clk),
      .rst_ni(rst),
      .d_i   (ack),
      .q_o   (sync_lvl)
   );

   // Edge history: previous synchronized level. Clearing it together with the
   // chain keeps reset entry from looking like a falling edge.
   assign ack_d = sync_lvl;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ack_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
      end
   end

   // Pulse is decoded from flops only, so it never sees the raw async input.
   always_comb begin
      pulse_d = 1'b0;
      case (EDGE_MODE)
         EDGE_RISE: pulse_d =  sync_lvl & ~ack_q;
         EDGE_FALL: pulse_d = ~sync_lvl &  ack_q;
         EDGE_BOTH: pulse_d =  sync_lvl ^  ack_q;
         default:   pulse_d = 1'b0;
      endcase
   end

   assign ack_double_FF = sync_lvl;
   assign ack_lvl_pulse = pulse_d;

endmodule : synchronizer

// File: tb/tb_synchronizer.sv
module tb_synchronizer;
   import synchronizer_pkg::*;

   localparam int MAXC = 1024;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ack = 1'b0;

   logic lvl_r, pls_r;   // N=2, rising
   logic lvl_f, pls_f;   // N=2, falling
   logic lvl_b, pls_b;   // N=2, both
   logic lvl_3, pls_3;   // N=3, rising

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // What was presented at each rising edge.
   bit ack_s [MAXC];
   bit rst_s [MAXC];

   always #5 clk = ~clk;

   synchronizer #(.SYNC_STAGES(2), .EDGE_MODE(EDGE_RISE)) dut_rise (
      .clk(clk), .rst(rst), .ack(ack), .ack_double_FF(lvl_r), .ack_lvl_pulse(pls_r));
   synchronizer #(.SYNC_STAGES(2), .EDGE_MODE(EDGE_FALL)) dut_fall (
      .clk(clk), .rst(rst), .ack(ack), .ack_double_FF(lvl_f), .ack_lvl_pulse(pls_f));
   synchronizer #(.SYNC_STAGES(2), .EDGE_MODE(EDGE_BOTH)) dut_both (
      .clk(clk), .rst(rst), .ack(ack), .ack_double_FF(lvl_b), .ack_lvl_pulse(pls_b));
   synchronizer #(.SYNC_STAGES(3), .EDGE_MODE(EDGE_RISE)) dut_n3 (
      .clk(clk), .rst(rst), .ack(ack), .ack_double_FF(lvl_3), .ack_lvl_pulse(pls_3));

   task automatic check(input string tag, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
      end
   endtask

   // Synchronized level after edge k for an n-stage synchronizer: the ack
   // sampled n-1 edges before, provided no reset was applied at any of the
   // last n edges (any reset in that window leaves a zero at the output).
   function automatic bit ref_level(int k, int n);
      if (k < 0) return 1'b0;
      for (int j = 0; j < n; j++) begin
         if (k - j < 0) return 1'b0;
         if (!rst_s[k-j]) return 1'b0;
      end
      return ack_s[k-n+1];
   endfunction

   // Edge seen by the pulse logic after edge k: previous level vs current,
   // with history forced to 0 on a reset edge.
   function automatic bit ref_pulse(int k, int n, int mode);
      bit cur, prev;
      cur  = ref_level(k, n);
      prev = rst_s[k] ? ref_level(k - 1, n) : 1'b0;
      case (mode)
         0:       return cur & ~prev;
         1:       return ~cur & prev;
         default: return cur ^ prev;
      endcase
   endfunction

   // Apply one cycle of stimulus, then check all instances away from the edge.
   task automatic step(input bit r, input bit a);
      rst = r;
      ack = a;
      @(posedge clk);
      if (cyc < MAXC) begin
         rst_s[cyc] = r;
         ack_s[cyc] = a;
      end
      @(negedge clk);
      if (cyc < MAXC) begin
         check("lvl_n2",     lvl_r, ref_level(cyc, 2));
         check("lvl_n2_f",   lvl_f, ref_level(cyc, 2));
         check("lvl_n3",     lvl_3, ref_level(cyc, 3));
         check("pulse_rise", pls_r, ref_pulse(cyc, 2, 0));
         check("pulse_fall", pls_f, ref_pulse(cyc, 2, 1));
         check("pulse_both", pls_b, ref_pulse(cyc, 2, 2));
         check("pulse_n3",   pls_3, ref_pulse(cyc, 3, 0));
      end
      cyc++;
   endtask

   initial begin
      int rise_cnt;
      int first_rise;
      int second_rise;

      // Reset hold with ack high: outputs must stay low.
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check("reset_lvl",   lvl_r, 1'b0);
      check("reset_pulse", pls_r, 1'b0);

      // Idle, then a single rise held 2 cycles.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check("single_rise_lvl",   lvl_r, 1'b1);
      check("single_rise_pulse", pls_r, 1'b1);
      step(1'b1, 1'b0);
      check("rise_pulse_once", pls_r, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

      // Short 1-cycle ack, then repeated pattern: 1 high, 4 low, 1 high.
      rise_cnt    = 0;
      first_rise  = -1;
      second_rise = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, (i == 0 || i == 5) ? 1'b1 : 1'b0);
         if (pls_r) begin
            rise_cnt++;
            if (first_rise < 0) first_rise = i;
            else second_rise = i;
         end
      end
      check("repeat_two_pulses", rise_cnt == 2, 1'b1);
      check("repeat_spacing",    (second_rise - first_rise) == 5, 1'b1);
      check("repeat_latency",    first_rise == 1, 1'b1);

      // Mid-operation reset with ack held high.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      check("midreset_lvl",   lvl_r, 1'b0);
      check("midreset_pulse", pls_f, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

      // Back-to-back toggling.
      for (int i = 0; i < 12; i++) step(1'b1, i[0]);

      // Randomized phase: mixed ack run lengths with occasional resets.
      for (int i = 0; i < 600; i++) begin
         bit r, a;
         r = ($urandom_range(0, 29) != 0);
         if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1);
         else a = ack;
         step(r, a);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_synchronizer
